serial_operand_serializer: RTL
==============================

# serial_operand_serializer

Upstream feeder for the serial magnitude comparator. It accepts two WIDTH-bit parallel operands with a start strobe and emits them MSB-first, one bit pair per clock, on `a`/`b`. It brackets each frame with a one-cycle comparator clear pulse before the first bit and a done pulse after the last bit. The comparator's `lt`/`gt`/`eq` outputs are valid once `done` is high.

## Interface
- `WIDTH`, default 3: operand width in bits; legal range is 1 to 32.
- `clk`  input  1: single system clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  input  1: request to serialize `op_a`/`op_b`; accepted only in IDLE.
- `op_a`  input  WIDTH: operand A; captured on the accepting edge.
- `op_b`  input  WIDTH: operand B; captured on the accepting edge.
- `a`  output  1: serial bit of A, MSB first; registered.
- `b`  output  1: serial bit of B, MSB first; registered.
- `bit_valid`  output  1: high while `a`/`b` carry a frame bit; registered.
- `cmp_clr`  output  1: one-cycle clear pulse to the comparator's `reset`; registered.
- `busy`  output  1: high from the accepting edge until the frame returns to IDLE; registered.
- `done`  output  1: one-cycle pulse after the last bit has been presented; registered.

## Operation
- Internal state:
  - Two WIDTH-bit left-shift registers, `sh_a` and `sh_b`.
  - Down-counter `cnt`, $clog2(WIDTH)+1 bits wide.
  - FSM with states IDLE, CLEAR, SHIFT and DONE.
- IDLE:
  - All outputs are 0.
  - `start`=1 captures `op_a`/`op_b` into `sh_a`/`sh_b`, sets `cnt`=WIDTH-1, raises `cmp_clr` and `busy`, and moves to CLEAR.
- CLEAR, exactly one cycle:
  - Drive `a`=`sh_a[WIDTH-1]` and `b`=`sh_b[WIDTH-1]`.
  - Set `bit_valid`=1 and `cmp_clr`=0, then move to SHIFT.
  - Shift both registers left by 1, filling with 0.
- SHIFT:
  - If `cnt`≠0: decrement `cnt`, drive the next MSB onto `a`/`b` with `bit_valid`=1, and shift again.
  - If `cnt`=0: set `a`=`b`=0, `bit_valid`=0 and `done`=1, and move to DONE.
- DONE: set `done`=0 and `busy`=0, and move to IDLE.
- `start` is ignored in every state except IDLE; there is no queuing.
- `op_a`/`op_b` may change freely after the accepting edge, because the frame uses the captured copies.
- The block does no arithmetic. Bit order is strictly `op_x[WIDTH-1]` down to `op_x[0]`.
- WIDTH=1: CLEAR presents the single bit, and SHIFT is entered with `cnt`=0, so it closes the frame on the next edge.

## Timing
- Reset has priority over all other inputs. On any edge with `reset`=1:
  - FSM goes to IDLE.
  - `a`, `b`, `bit_valid`, `cmp_clr`, `busy` and `done` all become 0.
  - `sh_a`, `sh_b` and `cnt` become 0.
  - `start` on that same edge is discarded.
- Frame timing, with the accepting edge as E0:
  - After E0: `cmp_clr`=1 and `busy`=1.
  - After E1: bit WIDTH-1 is on `a`/`b`, with `bit_valid`=1.
  - After E(1+i): bit WIDTH-1-i is on `a`/`b`, for i from 0 to WIDTH-1.
  - After E(WIDTH+1): `done`=1, `bit_valid`=0.
  - After E(WIDTH+2): `done`=0, `busy`=0, state IDLE.
- Comparator handoff:
  - The comparator samples each bit on the edge after it appears.
  - The comparator result is final while `done`=1.
- Throughput:
  - The earliest next accepting edge is E(WIDTH+3), giving a frame period of WIDTH+3 cycles.
  - `start` held high continuously yields back-to-back frames at that period.
- Reset mid-frame (in CLEAR, SHIFT or DONE):
  - Takes effect on that edge; the frame is aborted with no `done` pulse.
  - The comparator is cleared by the next frame's `cmp_clr`.
- `cmp_clr` and `bit_valid` are never high in the same cycle. `done` is never high while `bit_valid` is high.

## Test plan
- Basic frame, WIDTH=3, `op_a`=3'b110, `op_b`=3'b101, one-cycle `start`:
  - `cmp_clr` pulses for 1 cycle.
  - `a` then reads 1,1,0 and `b` reads 1,0,1, with `bit_valid` high for exactly 3 cycles.
  - `done` pulses 4 edges after the accepting edge.
  - With the comparator attached, `gt`=1 while `done` is high.
- Equal operands, WIDTH=3, `op_a`=`op_b`=3'b111: `a`=`b`=1,1,1 -> `eq`=1 at `done`.
- Zero operand, WIDTH=3, `op_a`=3'b000, `op_b`=3'b001: `a`=0,0,0 and `b`=0,0,1 -> `lt`=1 at `done`.
- Start while busy:
  - Pulse `start` again during SHIFT with different operands.
  - Required: the bit stream is unchanged, there is exactly one `done`, and `busy` does not extend.
- Mid-frame reset:
  - Assert `reset` for one edge after the second bit.
  - Required: all outputs 0 on the next cycle, no `done` pulse, and IDLE.
  - A following `start` runs a full clean frame.
- WIDTH=8 back-to-back, `start` held high, `op_a`=8'hA5, `op_b`=8'h5A:
  - `a`=10100101 and `b`=01011010.
  - Frames repeat every 11 cycles, with `done` once per frame.

Source files
------------

// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: frames two parallel operands MSB-first
// for the serial magnitude comparator, with clear and done pulses.
module serial_operand_serializer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             a,
   output logic             b,
   output logic             bit_valid,
   output logic             cmp_clr,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] w_sh_a;
   logic [WIDTH-1:0] w_sh_b;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt;
   logic             r_a;
   logic             r_b;
   logic             r_bit_valid;
   logic             r_cmp_clr;
   logic             r_busy;
   logic             r_done;
   logic             w_a;
   logic             w_b;
   logic             w_bit_valid;
   logic             w_cmp_clr;
   logic             w_busy;
   logic             w_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sh_a      <= '0;
         r_sh_b      <= '0;
         r_cnt       <= '0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_bit_valid <= 1'b0;
         r_cmp_clr   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_sh_a      <= w_sh_a;
         r_sh_b      <= w_sh_b;
         r_cnt       <= w_cnt;
         r_a         <= w_a;
         r_b         <= w_b;
         r_bit_valid <= w_bit_valid;
         r_cmp_clr   <= w_cmp_clr;
         r_busy      <= w_busy;
         r_done      <= w_done;
      end
   end

   // Outputs are computed here and registered, so every pin is a flop.
   always_comb begin
      w_state     = r_state;
      w_sh_a      = r_sh_a;
      w_sh_b      = r_sh_b;
      w_cnt       = r_cnt;
      w_a         = 1'b0;
      w_b         = 1'b0;
      w_bit_valid = 1'b0;
      w_cmp_clr   = 1'b0;
      w_busy      = r_busy;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (start) begin
               w_sh_a    = op_a;
               w_sh_b    = op_b;
               w_cnt     = CNT_INIT;
               w_cmp_clr = 1'b1;
               w_busy    = 1'b1;
               w_state   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_a         = r_sh_a[WIDTH-1];
            w_b         = r_sh_b[WIDTH-1];
            w_bit_valid = 1'b1;
            w_sh_a      = r_sh_a << 1;
            w_sh_b      = r_sh_b << 1;
            w_state     = S_SHIFT;
         end
         S_SHIFT: begin
            if (r_cnt != '0) begin
               w_cnt       = r_cnt - CNT_ONE;
               w_a         = r_sh_a[WIDTH-1];
               w_b         = r_sh_b[WIDTH-1];
               w_bit_valid = 1'b1;
               w_sh_a      = r_sh_a << 1;
               w_sh_b      = r_sh_b << 1;
            end else begin
               w_done  = 1'b1;
               w_state = S_DONE;
            end
         end
         S_DONE: begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end
         default: begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end
      endcase
   end

   assign a         = r_a;
   assign b         = r_b;
   assign bit_valid = r_bit_valid;
   assign cmp_clr   = r_cmp_clr;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
